power_enable_sequencer: RTL and testbench

- Parametrised successor to the 4-bit one-hot enable demux that drives test-chip block enables (OTAs, comparators, LDO bias variants).
- Adds a clocked break-before-make transition: all enables drop for a programmable dead time, then exactly one enable asserts, followed by a settle window before the block reports ready.
- Sits between the digital controller's select register and the analog block enable pins.
- Code 0 always means all blocks off (GND).

---
 rtl/power_enable_sequencer.sv | 161 ++++++++++++++++
 tb/tb_power_enable_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/power_enable_sequencer.sv
// power_enable_sequencer
//   Drives one-hot analog block enables from a select code. Switching between
//   blocks is break-before-make: every enable drops for DEAD_CYCLES, then one
//   enable rises, and ready is reported SETTLE_CYCLES later. Code 0 = all off.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (release synchronised internally)
//   sel_i    : requested block code
//   req_i    : single-cycle request strobe, sel_i sampled on the same edge
//   en_o     : registered enables, one-hot or zero; bit 0 never set
//   active_o : code currently applied to en_o (0 = all off)
//   busy_o   : transition in progress
//   ready_o  : idle and settled
//   err_o    : one-cycle pulse after an out-of-range request
module power_enable_sequencer #(
  parameter int SEL_W         = 4,
  parameter int N_OUT         = 16,
  parameter int DEAD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             req_i,
  output logic [N_OUT-1:0] en_o,
  output logic [SEL_W-1:0] active_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, BREAK, SETTLE} state_t;

  localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]   N_OUT_CODE  = (SEL_W + 1)'(N_OUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] target;
  logic             pend_valid;
  logic [SEL_W-1:0] pend_code;

  logic             sync_q1;
  logic             rst_sync_n;

  logic             sel_ok;
  logic             req_ok;
  logic             pend_any;
  logic [SEL_W-1:0] pend_next;
  logic             pend_diff;

  // Assertion reaches the FSM asynchronously through the synchroniser's clear;
  // release is seen two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1    <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      sync_q1    <= 1'b1;
      rst_sync_n <= sync_q1;
    end
  end

  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] code);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int unsigned i = 1; i < N_OUT; i++) v[i] = (code == SEL_W'(i));
    return v;
  endfunction

  // A request arriving on the very edge a phase ends is folded into the
  // pending decision so it is not lost.
  always_comb begin
    sel_ok    = ({1'b0, sel_i} < N_OUT_CODE);
    req_ok    = req_i && sel_ok;
    pend_any  = pend_valid || req_ok;
    pend_next = req_ok ? sel_i : pend_code;
    pend_diff = pend_any && (pend_next != target);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= IDLE;
      cnt        <= '0;
      target     <= '0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      en_o       <= '0;
      active_o   <= '0;
      busy_o     <= 1'b0;
      ready_o    <= 1'b1;
      err_o      <= 1'b0;
    end else begin
      err_o <= req_i && !sel_ok;
      case (state)
        IDLE: begin
          if (req_ok && (sel_i != active_o)) begin
            target   <= sel_i;
            state    <= BREAK;
            en_o     <= '0;
            active_o <= '0;
            busy_o   <= 1'b1;
            ready_o  <= 1'b0;
            cnt      <= DEAD_LOAD;
          end
        end
        BREAK: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (req_ok) begin
              pend_valid <= 1'b1;
              pend_code  <= sel_i;
            end
          end else begin
            pend_valid <= 1'b0;
            if (pend_diff) begin
              target <= pend_next;
              cnt    <= DEAD_LOAD;
            end else if (target == '0) begin
              state   <= IDLE;
              busy_o  <= 1'b0;
              ready_o <= 1'b1;
            end else begin
              state    <= SETTLE;
              en_o     <= onehot(target);
              active_o <= target;
              cnt      <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (req_ok) begin
              pend_valid <= 1'b1;
              pend_code  <= sel_i;
            end
          end else begin
            pend_valid <= 1'b0;
            if (pend_diff) begin
              target   <= pend_next;
              state    <= BREAK;
              en_o     <= '0;
              active_o <= '0;
              cnt      <= DEAD_LOAD;
            end else begin
              state   <= IDLE;
              busy_o  <= 1'b0;
              ready_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_enable_sequencer.sv
// Directed bench for power_enable_sequencer: a default-parameter instance and
// an N_OUT = 12 instance for out-of-range codes. Inputs change and outputs are
// sampled 1 ns after the rising edge; an independent monitor watches the
// enable invariants on the falling edge.
module tb_power_enable_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sel;
  logic        req;
  logic [15:0] en;
  logic [3:0]  active;
  logic        busy, ready, err;

  logic [3:0]  sel12;
  logic        req12;
  logic [11:0] en12;
  logic [3:0]  active12;
  logic        busy12, ready12, err12;

  int total = 0;
  int bad   = 0;

  power_enable_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sel_i(sel), .req_i(req),
    .en_o(en), .active_o(active), .busy_o(busy), .ready_o(ready), .err_o(err)
  );

  power_enable_sequencer #(.N_OUT(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .sel_i(sel12), .req_i(req12),
    .en_o(en12), .active_o(active12), .busy_o(busy12), .ready_o(ready12),
    .err_o(err12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [3:0] code);
    sel = code;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // Full transition to nonzero code k with no interference; called at cycle 1.
  task automatic expect_seq(input logic [3:0] k);
    logic [15:0] oh;
    oh = 16'd1 << k;
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("seq%0d_en_c%0d", k, c), 32'(en), (c >= 5) ? 32'(oh) : 32'd0);
      chk($sformatf("seq%0d_rdy_c%0d", k, c), 32'(ready), (c == 21) ? 32'd1 : 32'd0);
      chk($sformatf("seq%0d_busy_c%0d", k, c), 32'(busy), (c <= 20) ? 32'd1 : 32'd0);
      chk($sformatf("seq%0d_act_c%0d", k, c), 32'(active), (c >= 5) ? 32'(k) : 32'd0);
      if (c < 21) tick();
    end
  endtask

  // Invariants: at most one enable, and never a direct hop between two codes.
  logic [15:0] prev_en = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert ($countones(en) <= 1) else begin
        bad++;
        $error("FAIL popcount obs=%0h exp=onehot_or_zero", en);
      end
      total++;
      assert (!(prev_en != 16'd0 && en != 16'd0 && prev_en != en)) else begin
        bad++;
        $error("FAIL adjacent obs=%0h prev=%0h exp=zero_between", en, prev_en);
      end
    end
    prev_en <= en;
  end

  initial begin
    logic [15:0] e;
    logic [11:0] e12;

    rst_n = 1'b0; sel = '0; req = 1'b0; sel12 = '0; req12 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: reset defaults and code-0 no-op
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    do_req(4'd0);
    chk("noop0_busy", 32'(busy), 32'd0);
    chk("noop0_ready", 32'(ready), 32'd1);
    chk("noop0_en", 32'(en), 32'd0);

    // 2: 0 -> 1
    do_req(4'd1);
    expect_seq(4'd1);

    // 3: 1 -> 5, bit 1 drops on the first cycle
    do_req(4'd5);
    chk("b1_fell", 32'(en), 32'd0);
    expect_seq(4'd5);

    // same-code request is a no-op
    do_req(4'd5);
    chk("noop5_ready", 32'(ready), 32'd1);
    chk("noop5_en", 32'(en), 32'h20);

    // 4: toward 3, pending 7 then 9 (last wins), no ready between
    do_req(4'd3);
    for (int c = 1; c <= 41; c++) begin
      if (c <= 4 || (c >= 21 && c <= 24)) e = 16'h0000;
      else if (c <= 20) e = 16'h0008;
      else e = 16'h0200;
      chk($sformatf("pend_en_c%0d", c), 32'(en), 32'(e));
      chk($sformatf("pend_rdy_c%0d", c), 32'(ready), (c == 41) ? 32'd1 : 32'd0);
      if (c == 6) begin sel = 4'd7; req = 1'b1; end
      if (c == 7) begin sel = 4'd9; req = 1'b1; end
      if (c == 8) req = 1'b0;
      if (c < 41) tick();
    end
    chk("pend_active", 32'(active), 32'd9);
    chk("pend_busy", 32'(busy), 32'd0);

    // 5: invalid codes on N_OUT = 12
    sel12 = 4'd13; req12 = 1'b1; tick(); req12 = 1'b0;
    chk("inv13_err", 32'(err12), 32'd1);
    chk("inv13_en", 32'(en12), 32'd0);
    chk("inv13_busy", 32'(busy12), 32'd0);
    chk("inv13_ready", 32'(ready12), 32'd1);
    tick();
    chk("inv13_err_low", 32'(err12), 32'd0);
    sel12 = 4'd12; req12 = 1'b1; tick(); req12 = 1'b0;
    chk("inv12_err", 32'(err12), 32'd1);
    chk("inv12_busy", 32'(busy12), 32'd0);
    tick();
    chk("inv12_err_low", 32'(err12), 32'd0);

    sel12 = 4'd2; req12 = 1'b1; tick(); req12 = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      if (c <= 4 || (c >= 21 && c <= 24)) e12 = 12'h000;
      else if (c <= 20) e12 = 12'h004;
      else e12 = 12'h020;
      chk($sformatf("n12_en_c%0d", c), 32'(en12), 32'(e12));
      chk($sformatf("n12_err_c%0d", c), 32'(err12), (c == 8) ? 32'd1 : 32'd0);
      chk($sformatf("n12_rdy_c%0d", c), 32'(ready12), (c == 41) ? 32'd1 : 32'd0);
      if (c == 6) begin sel12 = 4'd5;  req12 = 1'b1; end
      if (c == 7) begin sel12 = 4'd13; req12 = 1'b1; end
      if (c == 8) req12 = 1'b0;
      if (c < 41) tick();
    end
    chk("n12_active", 32'(active12), 32'd5);

    // 6: reset in the middle of SETTLE toward 8
    do_req(4'd8);
    repeat (9) tick();
    chk("mid_en", 32'(en), 32'h100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", 32'(en), 32'd0);
    chk("async_active", 32'(active), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_ready", 32'(ready), 32'd1);
    chk("post_active", 32'(active), 32'd0);
    chk("post_en", 32'(en), 32'd0);
    do_req(4'd4);
    expect_seq(4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
